// File: rtl/fft8_ctrl_pkg.sv
// fft8_ctrl_pkg: shared constants, FSM state type and bit-reverse helper
// for the fft8 frame sequencer.
package fft8_ctrl_pkg;

   localparam int N = 8;

   typedef enum logic [1:0] {
      LOAD,
      COMPUTE,
      UNLOAD
   } state_t;

   function automatic logic [2:0] bitrev3(input logic [2:0] v);
      return {v[0], v[1], v[2]};
   endfunction

endpackage

// File: rtl/fft8.sv
// fft8: combinational 8-point DFT of real inputs A0..A7.
// X[k] = sum_n A[n] * W^(nk), with twiddles quantised to Q8
// (1.0 -> 256, sqrt(2)/2 -> 181). Each bin is accumulated at full
// precision and shifted right arithmetically by 8 once at the end.
module fft8 #(
   parameter int DW = 32
) (
   input  logic [DW-1:0] A0,
   input  logic [DW-1:0] A1,
   input  logic [DW-1:0] A2,
   input  logic [DW-1:0] A3,
   input  logic [DW-1:0] A4,
   input  logic [DW-1:0] A5,
   input  logic [DW-1:0] A6,
   input  logic [DW-1:0] A7,
   output logic [DW-1:0] Xr0,
   output logic [DW-1:0] Xr1,
   output logic [DW-1:0] Xr2,
   output logic [DW-1:0] Xr3,
   output logic [DW-1:0] Xr4,
   output logic [DW-1:0] Xr5,
   output logic [DW-1:0] Xr6,
   output logic [DW-1:0] Xr7,
   output logic [DW-1:0] Xi0,
   output logic [DW-1:0] Xi1,
   output logic [DW-1:0] Xi2,
   output logic [DW-1:0] Xi3,
   output logic [DW-1:0] Xi4,
   output logic [DW-1:0] Xi5,
   output logic [DW-1:0] Xi6,
   output logic [DW-1:0] Xi7
);

   localparam int AW = DW + 12;

   logic signed [AW-1:0] x [8];
   logic [DW-1:0] re [8];
   logic [DW-1:0] im [8];

   // cos(2*pi*m/8) in Q8
   function automatic logic signed [9:0] cos_q8(input logic [2:0] m);
      case (m)
         3'd0:    return  10'sd256;
         3'd1:    return  10'sd181;
         3'd3:    return -10'sd181;
         3'd4:    return -10'sd256;
         3'd5:    return -10'sd181;
         3'd7:    return  10'sd181;
         default: return  10'sd0;
      endcase
   endfunction

   // sign-extend the samples to accumulator width
   always_comb begin
      x[0] = AW'(signed'(A0));
      x[1] = AW'(signed'(A1));
      x[2] = AW'(signed'(A2));
      x[3] = AW'(signed'(A3));
      x[4] = AW'(signed'(A4));
      x[5] = AW'(signed'(A5));
      x[6] = AW'(signed'(A6));
      x[7] = AW'(signed'(A7));
   end

   // direct DFT; sin(theta) is taken as cos(theta - pi/2), i.e. index m-2
   always_comb begin : dft
      logic signed [AW-1:0] acc_re;
      logic signed [AW-1:0] acc_im;
      logic [2:0] m;
      acc_re = '0;
      acc_im = '0;
      m      = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         acc_re = '0;
         acc_im = '0;
         for (int unsigned n = 0; n < 8; n++) begin
            m      = 3'(k * n);
            acc_re = acc_re + x[n] * AW'(cos_q8(m));
            acc_im = acc_im - x[n] * AW'(cos_q8(m - 3'd2));
         end
         re[k] = DW'(acc_re >>> 8);
         im[k] = DW'(acc_im >>> 8);
      end
   end

   assign Xr0 = re[0];
   assign Xr1 = re[1];
   assign Xr2 = re[2];
   assign Xr3 = re[3];
   assign Xr4 = re[4];
   assign Xr5 = re[5];
   assign Xr6 = re[6];
   assign Xr7 = re[7];
   assign Xi0 = im[0];
   assign Xi1 = im[1];
   assign Xi2 = im[2];
   assign Xi3 = im[3];
   assign Xi4 = im[4];
   assign Xi5 = im[5];
   assign Xi6 = im[6];
   assign Xi7 = im[7];

endmodule

// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: collects 8 serial real samples, runs them through the
// combinational fft8 core in one cycle and streams the 8 complex bins out.
// Optional macro FFT8_FRAME_CTRL_BITREV_EN: emit bins in bit-reversed order.
module fft8_frame_ctrl
   import fft8_ctrl_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im,
   output logic [2:0]    out_idx,
   output logic          out_last,
   output logic          frame_err
);

   state_t state;
   state_t state_nxt;

   logic [2:0]    wcnt;
   logic [2:0]    rcnt;
   logic [2:0]    rsel;
   logic [DW-1:0] smp    [N];
   logic [DW-1:0] res_re [N];
   logic [DW-1:0] res_im [N];
   logic [DW-1:0] xr     [N];
   logic [DW-1:0] xi     [N];
   logic          accept;
   logic          xfer;

   assign accept = in_valid && (state == LOAD);
   assign xfer   = out_ready && (state == UNLOAD);

`ifdef FFT8_FRAME_CTRL_BITREV_EN
   assign rsel = bitrev3(rcnt);
`else
   assign rsel = rcnt;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (accept && (wcnt == 3'(N - 1) || in_last)) state_nxt = COMPUTE;
         COMPUTE: state_nxt = UNLOAD;
         UNLOAD:  if (xfer && rcnt == 3'(N - 1)) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // stream outputs; bin fields are zero outside UNLOAD
   always_comb begin
      in_ready  = (state == LOAD);
      out_valid = (state == UNLOAD);
      out_re    = '0;
      out_im    = '0;
      out_idx   = '0;
      out_last  = 1'b0;
      if (state == UNLOAD) begin
         out_re   = res_re[rsel];
         out_im   = res_im[rsel];
         out_idx  = rsel;
         out_last = (rcnt == 3'(N - 1));
      end
   end

   // write/read counters and framing-error pulse (high during COMPUTE)
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt      <= '0;
         rcnt      <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= accept && (wcnt == 3'(N - 1)) && !in_last;
         if (accept) wcnt <= in_last ? '0 : wcnt + 3'd1;
         if (xfer)   rcnt <= rcnt + 3'd1;
      end
   end

   // sample capture; an early in_last zero-pads the rest of the frame
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N; i++) smp[i] <= '0;
      end else if (accept) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (3'(i) == wcnt)                 smp[i] <= in_data;
            else if (in_last && 3'(i) > wcnt)  smp[i] <= '0;
         end
      end
   end

   // result capture at the end of the COMPUTE cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N; i++) begin
            res_re[i] <= '0;
            res_im[i] <= '0;
         end
      end else if (state == COMPUTE) begin
         for (int unsigned i = 0; i < N; i++) begin
            res_re[i] <= xr[i];
            res_im[i] <= xi[i];
         end
      end
   end

   fft8 #(.DW(DW)) u_fft8 (
      .A0 (smp[0]), .A1 (smp[1]), .A2 (smp[2]), .A3 (smp[3]),
      .A4 (smp[4]), .A5 (smp[5]), .A6 (smp[6]), .A7 (smp[7]),
      .Xr0(xr[0]),  .Xr1(xr[1]),  .Xr2(xr[2]),  .Xr3(xr[3]),
      .Xr4(xr[4]),  .Xr5(xr[5]),  .Xr6(xr[6]),  .Xr7(xr[7]),
      .Xi0(xi[0]),  .Xi1(xi[1]),  .Xi2(xi[2]),  .Xi3(xi[3]),
      .Xi4(xi[4]),  .Xi5(xi[5]),  .Xi6(xi[6]),  .Xi7(xi[7])
   );

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// tb_fft8_frame_ctrl: directed and random frames for fft8_frame_ctrl,
// checked against a direct-DFT reference with Q8 twiddles derived from $cos/$sin.
module tb_fft8_frame_ctrl;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_re;
   logic [DW-1:0] out_im;
   logic [2:0]    out_idx;
   logic          out_last;
   logic          frame_err;

   int total = 0;
   int bad   = 0;

   int          cq [8];
   int          sq [8];
   longint      frame_x [8];
   logic [31:0] exp_re [8];
   logic [31:0] exp_im [8];

   fft8_frame_ctrl #(.DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_re   (out_re),
      .out_im   (out_im),
      .out_idx  (out_idx),
      .out_last (out_last),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   function automatic int rnd(input real v);
      if (v >= 0.0) return $rtoi(v + 0.5);
      return -$rtoi(-v + 0.5);
   endfunction

   // transfer number -> bin index
   function automatic int ord(input int t);
`ifdef FFT8_FRAME_CTRL_BITREV_EN
      return ((t % 2) * 4) + (((t / 2) % 2) * 2) + (t / 4);
`else
      return t;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic timeout(input string tag);
      total++;
      bad++;
      $display("FAIL %s observed=no-handshake expected=handshake-within-bound", tag);
   endtask

   // X[k] = sum x[n] * (cos - j sin)(2*pi*n*k/8), twiddles in Q8, >>>8 at the end
   task automatic model();
      for (int k = 0; k < 8; k++) begin
         longint re = 0;
         longint im = 0;
         for (int n = 0; n < 8; n++) begin
            re += frame_x[n] * longint'(cq[(k * n) % 8]);
            im -= frame_x[n] * longint'(sq[(k * n) % 8]);
         end
         exp_re[k] = 32'(re >>> 8);
         exp_im[k] = 32'(im >>> 8);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_in_ready"},  in_ready,  1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_re"},    out_re,    0);
      chk({tag, "_out_im"},    out_im,    0);
      chk({tag, "_out_idx"},   out_idx,   0);
      chk({tag, "_out_last"},  out_last,  0);
      chk({tag, "_frame_err"}, frame_err, 0);
   endtask

   task automatic send_frame(input int len, input bit give_last, input bit gaps);
      int i = 0;
      int guard = 0;
      bit acc;
      bit err_exp;
      for (int j = len; j < 8; j++) frame_x[j] = 0;
      model();
      err_exp = (len == 8) && !give_last;
      while (i < len) begin
         if (guard > 400) begin
            timeout("send");
            in_valid = 1'b0;
            return;
         end
         guard++;
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data  = frame_x[i][31:0];
         in_last  = (i == len - 1) && (give_last || len < 8);
         chk("out_valid_load", out_valid, 0);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) i++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      chk("in_ready_compute",  in_ready,  0);
      chk("out_valid_compute", out_valid, 0);
      chk("frame_err_compute", frame_err, err_exp);
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
   task automatic receive(input int mode, input int stop);
      int t = 0;
      int guard = 0;
      int k;
      bit xf;
      @(posedge clk); #1;
      chk("first_bin_valid", out_valid, 1);
      while (t < 8) begin
         if (t == stop) begin
            out_ready = 1'b0;
            return;
         end
         if (guard > 400) begin
            timeout("receive");
            out_ready = 1'b0;
            return;
         end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (guard % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         guard++;
         k = ord(t);
         chk("in_ready_unload",  in_ready,  0);
         chk("out_valid_unload", out_valid, 1);
         chk("bin_re",           out_re,    exp_re[k]);
         chk("bin_im",           out_im,    exp_im[k]);
         chk("bin_idx",          out_idx,   k);
         chk("bin_last",         out_last,  t == 7);
         chk("frame_err_unload", frame_err, 0);
         xf = out_ready;
         @(posedge clk); #1;
         if (xf) t++;
      end
      out_ready = 1'b0;
      chk("in_ready_after_last",  in_ready,  1);
      chk("out_valid_after_last", out_valid, 0);
   endtask

   initial begin
      for (int m = 0; m < 8; m++) begin
         real a;
         a = 2.0 * 3.141592653589793 * m / 8.0;
         cq[m] = rnd(256.0 * $cos(a));
         sq[m] = rnd(256.0 * $sin(a));
      end

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;

      // all-ones frame
      for (int j = 0; j < 8; j++) frame_x[j] = 1;
      send_frame(8, 1'b1, 1'b0);
      receive(0, -1);

      // impulse
      for (int j = 0; j < 8; j++) frame_x[j] = (j == 0) ? 1 : 0;
      send_frame(8, 1'b1, 1'b0);
      receive(0, -1);

      // all-ones under sink backpressure
      for (int j = 0; j < 8; j++) frame_x[j] = 1;
      send_frame(8, 1'b1, 1'b0);
      receive(1, -1);

      // short frame: three ones, zero-padded
      for (int j = 0; j < 8; j++) frame_x[j] = (j < 3) ? 1 : 0;
      send_frame(3, 1'b1, 1'b0);
      receive(0, -1);

      // missing in_last on an all-ones frame
      for (int j = 0; j < 8; j++) frame_x[j] = 1;
      send_frame(8, 1'b0, 1'b0);
      receive(0, -1);

      // reset after 3 bins of a random frame, then an impulse frame
      for (int j = 0; j < 8; j++) frame_x[j] = longint'(int'($urandom()));
      send_frame(8, 1'b1, 1'b0);
      receive(0, 3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset("reset_mid_unload");
      @(posedge clk); #1;
      check_reset("idle_after_reset");
      for (int j = 0; j < 8; j++) frame_x[j] = (j == 0) ? 1 : 0;
      send_frame(8, 1'b1, 1'b0);
      receive(0, -1);

      // random frames with source gaps and random sink stalls
      for (int r = 0; r < 8; r++) begin
         int len;
         bit gl;
         len = $urandom_range(1, 8);
         gl  = 1'($urandom_range(0, 1));
         for (int j = 0; j < 8; j++) frame_x[j] = longint'(int'($urandom()));
         send_frame(len, gl, 1'b1);
         receive(2, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
